// File: rtl/vga_rect_filler_if.sv
// vga_rect_filler_if: request/pixel bundle between a draw controller and the
// rectangle filler.
//   master : controller side, drives start/mode/corners/fg and the downstream
//            stall, observes the pixel stream and busy/done.
//   slave  : filler side, the mirror image.
interface vga_rect_filler_if #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int COL_W = 3
);
  logic             start;
  logic [1:0]       mode;
  logic [X_W-1:0]   x0, x1;
  logic [Y_W-1:0]   y0, y1;
  logic [COL_W-1:0] fg;
  logic             stall;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [COL_W-1:0] colour;
  logic             plot;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, x0, x1, y0, y1, fg, stall,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, mode, x0, x1, y0, y1, fg, stall,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/vga_rect_filler.sv
// vga_rect_filler: rasterises one clipped rectangle onto the VGA pixel port,
// one pixel per non-stalled clock.
//   CLOCK_50 : system clock (rising edge)
//   resetn   : synchronous active-low reset
//   abort    : (only with VGA_RECT_FILLER_ABORT_EN) end the current draw early
//   bus      : vga_rect_filler_if.slave
//              in : start, mode, x0/x1, y0/y1, fg, stall
//              out: x, y, colour, plot, busy, done
// Modes: 0 row-major solid, 1 column-major solid, 2 row-major colour cycle,
// 3 clear the full screen to colour 0.
// Optional feature macro: VGA_RECT_FILLER_ABORT_EN.
module vga_rect_filler #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int COL_W = 3,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic CLOCK_50,
  input  logic resetn,
`ifdef VGA_RECT_FILLER_ABORT_EN
  input  logic abort,
`endif
  vga_rect_filler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  localparam logic [X_W-1:0]   XM    = X_W'(X_MAX);
  localparam logic [Y_W-1:0]   YM    = Y_W'(Y_MAX);
  localparam logic [COL_W-1:0] C_ONE = COL_W'(1);
  localparam logic [COL_W-1:0] C_TOP = '1;

  state_t state, state_nxt;

  logic abort_w;
`ifdef VGA_RECT_FILLER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // request captured at the start edge
  logic [1:0]       mode_q;
  logic [X_W-1:0]   x0_q, x1_q;
  logic [Y_W-1:0]   y0_q, y1_q;
  logic [COL_W-1:0] fg_q;

  // ordered bounds and the pixel cursor
  logic [X_W-1:0]   xl, xh, cx;
  logic [Y_W-1:0]   yl, yh, cy;
  logic [COL_W-1:0] ccol;

  // clamp + order, evaluated from the latched corners during SETUP
  logic [X_W-1:0] cx0, cx1, sxl, sxh;
  logic [Y_W-1:0] cy0, cy1, syl, syh;

  always_comb begin
    cx0 = (x0_q > XM) ? XM : x0_q;
    cx1 = (x1_q > XM) ? XM : x1_q;
    cy0 = (y0_q > YM) ? YM : y0_q;
    cy1 = (y1_q > YM) ? YM : y1_q;
    sxl = (cx0 < cx1) ? cx0 : cx1;
    sxh = (cx0 < cx1) ? cx1 : cx0;
    syl = (cy0 < cy1) ? cy0 : cy1;
    syh = (cy0 < cy1) ? cy1 : cy0;
    if (mode_q == 2'd3) begin
      sxl = '0;
      sxh = XM;
      syl = '0;
      syh = YM;
    end
  end

  logic accept, last;
  // abort suppresses plot so that plot&!stall always means "accepted"
  assign accept = (state == DRAW) && !bus.stall && !abort_w;
  assign last   = (cx == xh) && (cy == yh);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETUP;
      SETUP:   state_nxt = abort_w ? DONE : DRAW;
      DRAW: begin
        if (abort_w)            state_nxt = DONE;
        else if (accept && last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      mode_q <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      y0_q   <= '0;
      y1_q   <= '0;
      fg_q   <= '0;
      xl     <= '0;
      xh     <= '0;
      yl     <= '0;
      yh     <= '0;
      cx     <= '0;
      cy     <= '0;
      ccol   <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        mode_q <= bus.mode;
        x0_q   <= bus.x0;
        x1_q   <= bus.x1;
        y0_q   <= bus.y0;
        y1_q   <= bus.y1;
        fg_q   <= bus.fg;
      end

      if (state == SETUP && !abort_w) begin
        xl <= sxl;
        xh <= sxh;
        yl <= syl;
        yh <= syh;
        cx <= sxl;
        cy <= syl;
        case (mode_q)
          2'd2:    ccol <= C_ONE;
          2'd3:    ccol <= '0;
          default: ccol <= fg_q;
        endcase
      end

      // the cursor parks on the last pixel so x/y/colour hold afterwards
      if (accept && !last) begin
        if (mode_q == 2'd1) begin
          if (cy == yh) begin
            cy <= yl;
            cx <= cx + 1'b1;
          end else begin
            cy <= cy + 1'b1;
          end
        end else begin
          if (cx == xh) begin
            cx <= xl;
            cy <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        // colour cycle skips 0
        if (mode_q == 2'd2)
          ccol <= (ccol == C_TOP) ? C_ONE : ccol + C_ONE;
      end
    end
  end

  assign bus.x      = cx;
  assign bus.y      = cy;
  assign bus.colour = ccol;
  assign bus.plot   = accept;
  assign bus.busy   = (state == SETUP) || (state == DRAW);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_vga_rect_filler.sv
// tb_vga_rect_filler: directed bench for vga_rect_filler. Each step drives one
// draw, captures the pixel stream and checks it against hand-written vectors.
// Cycle numbering: the start pulse is driven in cycle 0; cycle 1 is SETUP.
module tb_vga_rect_filler;
  logic CLOCK_50 = 1'b0;
  logic resetn;
`ifdef VGA_RECT_FILLER_ABORT_EN
  logic abort;
`endif

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_rect_filler_if #(.X_W(8), .Y_W(7), .COL_W(3)) bus ();

  vga_rect_filler #(.X_W(8), .Y_W(7), .COL_W(3), .X_MAX(159), .Y_MAX(119)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
`ifdef VGA_RECT_FILLER_ABORT_EN
    .abort    (abort),
`endif
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;
  int qx[$], qy[$], qc[$];
  int first_plot, done_cyc;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic setreq(input int m, input int ax0, input int ay0, input int ax1,
                        input int ay1, input int c);
    bus.mode = 2'(m);
    bus.x0   = 8'(ax0);
    bus.y0   = 7'(ay0);
    bus.x1   = 8'(ax1);
    bus.y1   = 7'(ay1);
    bus.fg   = 3'(c);
  endtask

  // Runs one draw. stall is high in cycles [stall_s, stall_s+stall_n);
  // start is re-pulsed in cycle repulse; abort is raised in cycle abort_cyc.
  task automatic run(input string tag, input int stall_s, input int stall_n,
                     input int repulse, input int abort_cyc);
    int cyc;
    int hx, hy, hc;
    qx.delete(); qy.delete(); qc.delete();
    first_plot = -1;
    done_cyc   = -1;
    hx = 0; hy = 0; hc = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    chk({tag, "_setup_busy"}, 32'(bus.busy), 1);
    chk({tag, "_setup_plot"}, 32'(bus.plot), 0);
    while (cyc < 400 && done_cyc < 0) begin
      tick();
      cyc++;
      bus.stall = (cyc >= stall_s) && (cyc < stall_s + stall_n);
      bus.start = (cyc == repulse);
      // corners and mode change under the running draw; they must be ignored
      if (cyc == 2) setreq(1, 99, 50, 1, 0, 6);
`ifdef VGA_RECT_FILLER_ABORT_EN
      abort = (cyc == abort_cyc);
`endif
      #1;
      if (bus.stall && bus.busy) begin
        chk({tag, "_stall_plot"}, 32'(bus.plot), 0);
        if (cyc == stall_s) begin
          hx = int'(bus.x); hy = int'(bus.y); hc = int'(bus.colour);
        end else begin
          chk({tag, "_stall_hold_x"}, 32'(bus.x), 32'(hx));
          chk({tag, "_stall_hold_y"}, 32'(bus.y), 32'(hy));
          chk({tag, "_stall_hold_c"}, 32'(bus.colour), 32'(hc));
        end
      end
      if (bus.plot === 1'b1) begin
        qx.push_back(int'(bus.x));
        qy.push_back(int'(bus.y));
        qc.push_back(int'(bus.colour));
        if (first_plot < 0) first_plot = cyc;
      end
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        chk({tag, "_done_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done_plot"}, 32'(bus.plot), 0);
      end
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
`ifdef VGA_RECT_FILLER_ABORT_EN
    abort = 1'b0;
`endif
    if (done_cyc < 0) chk({tag, "_timeout"}, 0, 1);
    // one cycle after the done pulse: back in IDLE, outputs hold
    tick();
    chk({tag, "_post_done"}, 32'(bus.done), 0);
    chk({tag, "_post_busy"}, 32'(bus.busy), 0);
    if (abort_cyc < 0 && qx.size() > 0) begin
      chk({tag, "_hold_x"}, 32'(bus.x), 32'(qx[qx.size()-1]));
      chk({tag, "_hold_y"}, 32'(bus.y), 32'(qy[qy.size()-1]));
    end
    tick();
  endtask

  task automatic cmp_seq(input string tag, input int ex[$], input int ey[$], input int ec[$]);
    chk({tag, "_count"}, 32'(qx.size()), 32'(ex.size()));
    for (int i = 0; i < ex.size(); i++) begin
      if (i < qx.size()) begin
        chk($sformatf("%s_x%0d", tag, i), 32'(qx[i]), 32'(ex[i]));
        chk($sformatf("%s_y%0d", tag, i), 32'(qy[i]), 32'(ey[i]));
        chk($sformatf("%s_c%0d", tag, i), 32'(qc[i]), 32'(ec[i]));
      end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    setreq(0, 0, 0, 0, 0, 0);
`ifdef VGA_RECT_FILLER_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    chk("rst_x",    32'(bus.x), 0);
    chk("rst_y",    32'(bus.y), 0);
    chk("rst_col",  32'(bus.colour), 0);
    chk("rst_plot", 32'(bus.plot), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    resetn = 1'b1;
    tick();

    // mode 0, row-major solid
    setreq(0, 2, 3, 4, 4, 5);
    run("m0", -10, 0, -1, -1);
    cmp_seq("m0", '{2, 3, 4, 2, 3, 4}, '{3, 3, 3, 4, 4, 4}, '{5, 5, 5, 5, 5, 5});
    chk("m0_first_plot", 32'(first_plot), 2);
    chk("m0_done_cyc",   32'(done_cyc), 8);

    // mode 1, column-major solid, same corners
    setreq(1, 2, 3, 4, 4, 5);
    run("m1", -10, 0, -1, -1);
    cmp_seq("m1", '{2, 2, 3, 3, 4, 4}, '{3, 4, 3, 4, 3, 4}, '{5, 5, 5, 5, 5, 5});
    chk("m1_done_cyc", 32'(done_cyc), 8);

    // clamp and swap, start re-pulsed in cycle 3
    setreq(0, 200, 127, 157, 118, 3);
    run("clamp", -10, 0, 3, -1);
    cmp_seq("clamp", '{157, 158, 159, 157, 158, 159}, '{118, 118, 118, 119, 119, 119},
            '{3, 3, 3, 3, 3, 3});
    chk("clamp_done_cyc", 32'(done_cyc), 8);

    // mode 2 colour cycle over a 1x9 row
    setreq(2, 10, 5, 18, 5, 0);
    run("m2", -10, 0, -1, -1);
    cmp_seq("m2", '{10, 11, 12, 13, 14, 15, 16, 17, 18}, '{5, 5, 5, 5, 5, 5, 5, 5, 5},
            '{1, 2, 3, 4, 5, 6, 7, 1, 2});
    chk("m2_done_cyc", 32'(done_cyc), 11);

    // degenerate rectangle
    setreq(1, 7, 7, 7, 7, 4);
    run("one", -10, 0, -1, -1);
    cmp_seq("one", '{7}, '{7}, '{4});
    chk("one_done_cyc", 32'(done_cyc), 3);

    // stall cycles 4..6 while the third pixel is presented
    setreq(0, 0, 0, 3, 1, 6);
    run("stall", 4, 3, -1, -1);
    cmp_seq("stall", '{0, 1, 2, 3, 0, 1, 2, 3}, '{0, 0, 0, 0, 1, 1, 1, 1},
            '{6, 6, 6, 6, 6, 6, 6, 6});
    chk("stall_first_plot", 32'(first_plot), 2);
    chk("stall_done_cyc",   32'(done_cyc), 13);

    // reset in the middle of a draw
    setreq(0, 0, 0, 20, 10, 7);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_busy", 32'(bus.busy), 1);
    resetn = 1'b0;
    tick();
    chk("mrst_x",    32'(bus.x), 0);
    chk("mrst_y",    32'(bus.y), 0);
    chk("mrst_col",  32'(bus.colour), 0);
    chk("mrst_plot", 32'(bus.plot), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_done", 32'(bus.done), 0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_done", 32'(bus.done), 0);
      chk("mrst_idle",    32'(bus.busy), 0);
    end

`ifdef VGA_RECT_FILLER_ABORT_EN
    // full-screen clear aborted after 10 accepted pixels (cycles 2..11)
    setreq(3, 5, 5, 6, 6, 7);
    run("abort", -10, 0, -1, 12);
    cmp_seq("abort", '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    chk("abort_done_cyc", 32'(done_cyc), 13);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
